// File: rtl/fwd_pkg.sv
// Shared types and encodings for the operand forwarding / load-use hazard unit.
// Tag addresses are zero-extended to TAG_AW, so REG_AW must not exceed TAG_AW.
package fwd_pkg;

  localparam int DEF_REG_AW     = 5;
  localparam int DEF_NUM_SRC    = 2;
  localparam int DEF_FWD_STAGES = 2;

  localparam int TAG_AW = 8;

  localparam int SEL_RF    = 0;
  localparam int SEL_EXMEM = 1;
  localparam int SEL_MEMWB = 2;

  typedef struct packed {
    logic              valid;
    logic [TAG_AW-1:0] rd;
    logic              regwrite;
    logic              memread;
  } tag_t;

  localparam tag_t TAG_BUBBLE = '{
    valid:    1'b0,
    rd:       '0,
    regwrite: 1'b0,
    memread:  1'b0
  };

  function automatic int stage_sel(input int s);
    if (s == 1)
      return SEL_EXMEM;
    else if (s == 2)
      return SEL_MEMWB;
    else
      return s;
  endfunction

endpackage

// File: rtl/fwd_match.sv
// One source operand against every forwardable stage.
// The youngest matching writer wins; x0 never matches.
module fwd_match
  import fwd_pkg::*;
#(
  parameter int FWD_STAGES = DEF_FWD_STAGES,
  parameter int SEL_W      = $clog2(FWD_STAGES + 1)
) (
  input  logic                  rs_en,
  input  logic [TAG_AW-1:0]     rs,
  input  logic [FWD_STAGES-1:0] wr_ok,
  input  logic [TAG_AW-1:0]     wr_rd [FWD_STAGES],
  output logic [SEL_W-1:0]      sel
);

  always_comb begin
    sel = SEL_W'(SEL_RF);
    for (int s = FWD_STAGES; s >= 1; s--) begin
      if (rs_en && (rs != '0) && wr_ok[s-1] &&
          (wr_rd[s-1] == rs))
        sel = SEL_W'(stage_sel(s));
    end
  end

endmodule

// File: rtl/forwarding_hazard_unit.sv
// Tag pipeline from EX downwards, per-source forwarding selects,
// load-use stall detection and a saturating stall counter.
module forwarding_hazard_unit
  import fwd_pkg::*;
#(
  parameter  int REG_AW     = DEF_REG_AW,
  parameter  int NUM_SRC    = DEF_NUM_SRC,
  parameter  int FWD_STAGES = DEF_FWD_STAGES,
  localparam int SEL_W      = $clog2(FWD_STAGES + 1)
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       id_valid,
  input  logic [NUM_SRC*REG_AW-1:0]  id_rs,
  input  logic [NUM_SRC-1:0]         id_rs_used,
  input  logic [REG_AW-1:0]          id_rd,
  input  logic                       id_regwrite,
  input  logic                       id_memread,
  input  logic                       flush,
  output logic [NUM_SRC*SEL_W-1:0]   fwd_sel,
  output logic                       stall,
  output logic                       pc_write,
  output logic                       if_id_write,
  output logic [15:0]                stall_count
);

  tag_t                  pipe [FWD_STAGES+1];
  logic [REG_AW-1:0]     ex_rs [NUM_SRC];
  logic [NUM_SRC-1:0]    ex_used;
  logic [NUM_SRC-1:0]    use_hit;
  logic                  ld_hzd;
  logic [FWD_STAGES-1:0] wr_ok;
  logic [TAG_AW-1:0]     wr_rd [FWD_STAGES];

  always_comb begin
    use_hit = '0;
    for (int k = 0; k < NUM_SRC; k++) begin
      use_hit[k] = id_rs_used[k] &&
        (TAG_AW'(id_rs[k*REG_AW +: REG_AW]) == pipe[0].rd);
    end
  end

  assign ld_hzd = pipe[0].valid & pipe[0].memread &
                  pipe[0].regwrite & (pipe[0].rd != '0);

  assign stall       = id_valid & ld_hzd & (|use_hit);
  assign pc_write    = ~stall;
  assign if_id_write = ~stall;

  // Downstream stages always advance; only EX takes bubbles.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int s = 0; s <= FWD_STAGES; s++)
        pipe[s] <= TAG_BUBBLE;
      for (int k = 0; k < NUM_SRC; k++)
        ex_rs[k] <= '0;
      ex_used     <= '0;
      stall_count <= '0;
    end else begin
      for (int s = 1; s <= FWD_STAGES; s++)
        pipe[s] <= pipe[s-1];
      if (id_valid && !stall && !flush) begin
        pipe[0] <= '{
          valid:    1'b1,
          rd:       TAG_AW'(id_rd),
          regwrite: id_regwrite,
          memread:  id_memread
        };
        for (int k = 0; k < NUM_SRC; k++)
          ex_rs[k] <= id_rs[k*REG_AW +: REG_AW];
        ex_used <= id_rs_used;
      end else begin
        pipe[0] <= TAG_BUBBLE;
        ex_used <= '0;
      end
      if (stall && (stall_count != 16'hFFFF))
        stall_count <= stall_count + 16'd1;
    end
  end

  for (genvar s = 1; s <= FWD_STAGES; s++) begin : g_wr
    assign wr_ok[s-1] = pipe[s].valid & pipe[s].regwrite;
    assign wr_rd[s-1] = pipe[s].rd;
  end

  for (genvar k = 0; k < NUM_SRC; k++) begin : g_src
    fwd_match #(
      .FWD_STAGES (FWD_STAGES),
      .SEL_W      (SEL_W)
    ) u_match (
      .rs_en (pipe[0].valid & ex_used[k]),
      .rs    (TAG_AW'(ex_rs[k])),
      .wr_ok (wr_ok),
      .wr_rd (wr_rd),
      .sel   (fwd_sel[k*SEL_W +: SEL_W])
    );
  end

endmodule

// File: doc/forwarding_hazard_unit.md
FORWARDING_HAZARD_UNIT -- requirements
Module: forwarding_hazard_unit

Interface
REQ-001 The block SHALL have parameter REG_AW, default 5, meaning register-address width.
REQ-002 The block SHALL have parameter NUM_SRC, default 2, meaning source operands per instruction (1..3).
REQ-003 The block SHALL have parameter FWD_STAGES, default 2, meaning forwardable downstream stages (1..4); stage 1 is EX/MEM, stage 2 is MEM/WB, and so on.
REQ-004 The block SHALL have localparam SEL_W = clog2(FWD_STAGES+1).
REQ-005 The block SHALL have port clk, input, 1, the single clock.
REQ-006 The block SHALL have port reset, input, 1, synchronous active-high reset.
REQ-007 The block SHALL have port id_valid, input, 1, an instruction is present in ID.
REQ-008 The block SHALL have port id_rs, input, NUM_SRC*REG_AW, ID source addresses; source k is at bits [k*REG_AW +: REG_AW].
REQ-009 The block SHALL have port id_rs_used, input, NUM_SRC, per-source "operand actually read".
REQ-010 The block SHALL have port id_rd, input, REG_AW, ID destination.
REQ-011 The block SHALL have port id_regwrite, input, 1, ID writes a register.
REQ-012 The block SHALL have port id_memread, input, 1, ID is a load.
REQ-013 The block SHALL have port flush, input, 1, squash the instruction entering EX.
REQ-014 The block SHALL have port fwd_sel, output, NUM_SRC*SEL_W, per-source select for the EX-stage operand.
REQ-015 The block SHALL have port stall, output, 1, load-use hazard detected this cycle.
REQ-016 The block SHALL have port pc_write, output, 1, PC update enable.
REQ-017 The block SHALL have port if_id_write, output, 1, IF/ID register enable.
REQ-018 The block SHALL have port stall_count, output, 16, saturating count of stall cycles.

Function
REQ-019 The block SHALL hold a tag pipeline of FWD_STAGES+1 entries: entry 0 is EX, entry s is stage s. Each entry holds {valid, rd, regwrite, memread}; entry 0 additionally holds rs[NUM_SRC] and rs_used.
REQ-020 On each clk edge, entry s SHALL load entry s-1 for s>=1, unconditionally; downstream stages never stall.
REQ-021 On each clk edge, entry 0 SHALL load ID fields when id_valid=1, stall=0 and flush=0; otherwise it SHALL load a bubble (valid=0, regwrite=0, memread=0).
REQ-022 When flush and stall are both 1, flush SHALL win: a bubble is inserted, and pc_write and if_id_write are still driven by stall.
REQ-023 stall SHALL be combinational: 1 iff id_valid, and entry0.valid, entry0.memread, entry0.regwrite, entry0.rd!=0, and some k with id_rs_used[k] and id_rs[k]==entry0.rd.
REQ-024 The block SHALL drive pc_write = if_id_write = ~stall.
REQ-025 fwd_sel[k] SHALL be combinational from entry0.rs[k]: the smallest s in 1..FWD_STAGES where entry s is valid, has regwrite=1, has rd!=0, and rd==entry0.rs[k] yields fwd_sel[k]=s; if no such s exists, 0 (register file).
REQ-026 fwd_sel[k] SHALL be 0 when entry0.valid=0 or rs_used[k]=0.
REQ-027 Register x0 SHALL never be forwarded or stalled on.
REQ-028 stall_count SHALL increment by 1 on each edge with stall=1 and saturate at 0xFFFF.
REQ-029 Entry 1 matching with memread=1 SHALL be unreachable by construction; the bench asserts this.

Reset
REQ-030 On reset=1 at a clk edge, all entries SHALL become bubbles and stall_count SHALL become 0.
REQ-031 The cycle after reset, outputs SHALL be fwd_sel=0, stall=0, pc_write=1, if_id_write=1.
REQ-032 Reset mid-stall SHALL discard the hazard; no stall cycle is counted on that edge.

Structure
REQ-033 Shared package fwd_pkg SHALL hold: the tag-entry struct typedef, the select encodings (SEL_RF=0, SEL_EXMEM=1, SEL_MEMWB=2), and the default parameter values.
REQ-034 Sub-module fwd_match (one source vs FWD_STAGES entries, priority encoder) SHALL be instantiated NUM_SRC times.

Verification
REQ-035 ALU chain: add x5 then add x6,x5,x5 back-to-back -> fwd_sel = {1,1} in the consumer's EX cycle, and stall never asserts.
REQ-036 Load-use: lw x7 then add x8,x7,x1 -> stall=1 for exactly one cycle, pc_write=0, a bubble in EX, then fwd_sel[0]=2 and stall_count=1.
REQ-037 Double hazard: add x3 followed by add x3 then use x3 -> fwd_sel=1 (youngest wins), not 2.
REQ-038 x0 / unused: writer rd=0, then a reader with rs=0, and rs_used=0 against a matching rd -> fwd_sel=0 and stall=0.
REQ-039 Flush+stall: lw x9, then a consumer with flush=1 on the same cycle -> bubble inserted, pc_write=0 for 1 cycle.
REQ-040 Reset during stall and saturation: reset asserted while stall=1 -> all outputs at reset values on the next cycle; with a 65540-cycle forced stall, stall_count holds 0xFFFF.
